// File: rtl/sensor_debouncer.sv
// -----------------------------------------------------------------------------
// sensor_debouncer
//
// Input-side front end for the irrigation controller. Synchronises and
// debounces the six raw board switches {T,Ua,Us,L,M,H} (H = bit 0), publishes
// the debounced values with a one-cycle change strobe, and runs a persistence
// filtered consistency check on the three tank-level sensors.
//
// Ports:
//   clock        in   1  system clock
//   Rst          in   1  synchronous, active-high reset
//   raw_in       in   6  unsynchronised switches {T,Ua,Us,L,M,H}
//   stable_out   out  6  debounced values, same bit order
//   changed      out  1  one-cycle pulse when any stable_out bit updates
//   sample_tick  out  1  one-cycle pulse on each sample instant
//   level_state  out  2  0 OK, 1 SUSPECT, 2 FAULT, 3 RECOVER
//   level_error  out  1  high in FAULT or RECOVER
//
// Build option:
//   SENSOR_SIM_BYPASS_EN  when defined, the DIV divider is removed and every
//                         cycle after reset is a sample tick (fast simulation).
// -----------------------------------------------------------------------------
module sensor_debouncer #(
  parameter int unsigned DIV            = 50000,
  parameter int unsigned STABLE_SAMPLES = 8,
  parameter int unsigned ERR_HOLD       = 16
) (
  input  logic       clock,
  input  logic       Rst,
  input  logic [5:0] raw_in,
  output logic [5:0] stable_out,
  output logic       changed,
  output logic       sample_tick,
  output logic [1:0] level_state,
  output logic       level_error
);

  localparam int unsigned NumBits = 6;
  localparam int unsigned CntW    = $clog2(STABLE_SAMPLES + 1);
  localparam int unsigned ErrW    = $clog2(ERR_HOLD + 1);

  localparam logic [CntW:0] StableLimit = STABLE_SAMPLES[CntW:0];
  localparam logic [ErrW:0] ErrLimit    = ERR_HOLD[ErrW:0];

  typedef enum logic [1:0] {
    StOk      = 2'd0,
    StSuspect = 2'd1,
    StFault   = 2'd2,
    StRecover = 2'd3
  } level_state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; only the second stage feeds the debouncer.
  // ---------------------------------------------------------------------------
  logic [NumBits-1:0] r_sync1;
  logic [NumBits-1:0] r_sync2;

  always_ff @(posedge clock) begin
    if (Rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample tick. r_tick is the registered strobe; a "tick cycle" is any cycle
  // on which r_tick is high.
  // ---------------------------------------------------------------------------
  logic r_tick;

`ifdef SENSOR_SIM_BYPASS_EN
  always_ff @(posedge clock) begin
    if (Rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b1;
    end
  end
`else
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  logic [DivW-1:0] r_div_cnt;

  // With DIV=1 the counter sits at 0 == DivLast, so the tick stays high.
  always_ff @(posedge clock) begin
    if (Rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      if (r_div_cnt == DivLast) begin
        r_div_cnt <= '0;
        r_tick    <= 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
        r_tick    <= 1'b0;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-bit debounce. A bit's counter holds the number of consecutive tick
  // samples that disagreed with the published value; one agreeing sample
  // restarts it, so short glitches never reach stable_out.
  // ---------------------------------------------------------------------------
  logic [NumBits-1:0] r_stable;
  logic [CntW-1:0]    r_db_cnt     [NumBits];
  logic [CntW-1:0]    w_db_cnt_nxt [NumBits];
  logic [CntW:0]      w_db_cnt_inc [NumBits];
  logic [NumBits-1:0] w_stable_nxt;
  logic [NumBits-1:0] w_req;
  logic               r_changed;

  always_comb begin
    w_stable_nxt = r_stable;
    w_req        = '0;
    for (int i = 0; i < NumBits; i++) begin
      w_db_cnt_inc[i] = {1'b0, r_db_cnt[i]} + 1'b1;
      w_db_cnt_nxt[i] = r_db_cnt[i];
      if (r_tick) begin
        if (r_sync2[i] == r_stable[i]) begin
          w_db_cnt_nxt[i] = '0;
        end else if (w_db_cnt_inc[i] == StableLimit) begin
          w_stable_nxt[i] = ~r_stable[i];
          w_db_cnt_nxt[i] = '0;
          w_req[i]        = 1'b1;
        end else begin
          w_db_cnt_nxt[i] = w_db_cnt_inc[i][CntW-1:0];
        end
      end
    end
  end

  // Non-tick cycles see w_req == 0 and unchanged next values, so state holds.
  always_ff @(posedge clock) begin
    if (Rst) begin
      r_stable  <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < NumBits; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_stable  <= w_stable_nxt;
      r_changed <= |w_req;
      for (int i = 0; i < NumBits; i++) begin
        r_db_cnt[i] <= w_db_cnt_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Level consistency. Sensors are stacked bottom-up (L lowest), so a higher
  // sensor may only read wet when every sensor below it is wet: valid {L,M,H}
  // codes are 000, 100, 110, 111. Uses r_stable as it stands before this
  // tick's debounce update.
  // ---------------------------------------------------------------------------
  logic w_level_ok;

  always_comb begin
    w_level_ok = 1'b0;
    case (r_stable[2:0])
      3'b000, 3'b100, 3'b110, 3'b111: w_level_ok = 1'b1;
      default:                        w_level_ok = 1'b0;
    endcase
  end

  level_state_e  r_state;
  logic [ErrW-1:0] r_err_cnt;
  logic [ErrW:0]   w_err_inc;
  logic            r_level_error;

  assign w_err_inc = {1'b0, r_err_cnt} + 1'b1;

  // r_err_cnt counts consecutive ticks disagreeing with the current regime:
  // invalid ticks while healthy (OK/SUSPECT), valid ticks while faulted
  // (FAULT/RECOVER).
  always_ff @(posedge clock) begin
    if (Rst) begin
      r_state       <= StOk;
      r_err_cnt     <= '0;
      r_level_error <= 1'b0;
    end else if (r_tick) begin
      case (r_state)
        StOk: begin
          if (!w_level_ok) begin
            r_state   <= StSuspect;
            r_err_cnt <= ErrW'(1);
          end
        end
        StSuspect: begin
          if (w_level_ok) begin
            r_state   <= StOk;
            r_err_cnt <= '0;
          end else if (w_err_inc == ErrLimit) begin
            r_state       <= StFault;
            r_err_cnt     <= '0;
            r_level_error <= 1'b1;
          end else begin
            r_err_cnt <= w_err_inc[ErrW-1:0];
          end
        end
        StFault: begin
          if (w_level_ok) begin
            r_state   <= StRecover;
            r_err_cnt <= ErrW'(1);
          end
        end
        StRecover: begin
          if (!w_level_ok) begin
            r_state   <= StFault;
            r_err_cnt <= '0;
          end else if (w_err_inc == ErrLimit) begin
            r_state       <= StOk;
            r_err_cnt     <= '0;
            r_level_error <= 1'b0;
          end else begin
            r_err_cnt <= w_err_inc[ErrW-1:0];
          end
        end
        default: begin
          r_state       <= StOk;
          r_err_cnt     <= '0;
          r_level_error <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are all direct register taps.
  // ---------------------------------------------------------------------------
  assign stable_out  = r_stable;
  assign changed     = r_changed;
  assign sample_tick = r_tick;
  assign level_state = r_state;
  assign level_error = r_level_error;

endmodule
